// File: rtl/lap_recorder.sv
// Lap memory for a BCD stopwatch: stores up to DEPTH split times in a circular
// buffer and lets the user step back through them, newest first.
module lap_recorder #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  min_in,
    input  logic [7:0]  sec_in,
    input  logic        cnt_en,
    input  logic        lap_pulse,
    input  logic        view_pulse,
    input  logic        clr_pulse,
    output logic [15:0] display,
    output logic [3:0]  lap_count,
    output logic [2:0]  view_idx,
    output logic        recall,
    output logic        full
);

    typedef enum logic {
        LIVE,
        RECALL
    } state_e;

    localparam logic [2:0] PTR_MAX = 3'(DEPTH - 1);
    localparam logic [3:0] CNT_MAX = 4'(DEPTH);

    state_e      state_q, state_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  lap_count_q, lap_count_d;
    logic [2:0]  view_idx_q, view_idx_d;
    logic [15:0] display_q, display_d;
    logic [15:0] mem_q [DEPTH];

    logic        wr_en;
    logic [15:0] live_val;
    logic [3:0]  rd_sum;
    logic [2:0]  rd_idx;

    always_comb begin
        live_val    = {min_in, sec_in};
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        lap_count_d = lap_count_q;
        view_idx_d  = view_idx_q;
        wr_en       = 1'b0;

        if (clr_pulse) begin
            state_d     = LIVE;
            wr_ptr_d    = '0;
            lap_count_d = '0;
            view_idx_d  = '0;
        end else if (state_q == LIVE) begin
            // A lap request while stopped is void, so it does not mask a view request.
            if (lap_pulse && cnt_en) begin
                wr_en    = 1'b1;
                wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 3'd1;
                if (lap_count_q != CNT_MAX) begin
                    lap_count_d = lap_count_q + 4'd1;
                end
            end else if (view_pulse && (lap_count_q != '0)) begin
                state_d    = RECALL;
                view_idx_d = '0;
            end
        end else begin
            if (lap_pulse) begin
                state_d    = LIVE;
                view_idx_d = '0;
            end else if (view_pulse) begin
                if ({1'b0, view_idx_q} == (lap_count_q - 4'd1)) begin
                    state_d    = LIVE;
                    view_idx_d = '0;
                end else begin
                    view_idx_d = view_idx_q + 3'd1;
                end
            end
        end
    end

    // Display follows the next-state view so recall and data change on the same edge.
    always_comb begin
        rd_sum = {1'b0, wr_ptr_d} + CNT_MAX - 4'd1 - {1'b0, view_idx_d};
        rd_idx = (rd_sum >= CNT_MAX) ? 3'(rd_sum - CNT_MAX) : rd_sum[2:0];
        display_d = (state_d == RECALL) ? mem_q[rd_idx] : live_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LIVE;
            wr_ptr_q    <= '0;
            lap_count_q <= '0;
            view_idx_q  <= '0;
            display_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            lap_count_q <= lap_count_d;
            view_idx_q  <= view_idx_d;
            display_q   <= display_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= live_val;
        end
    end

    assign display   = display_q;
    assign lap_count = lap_count_q;
    assign view_idx  = view_idx_q;
    assign recall    = (state_q == RECALL);
    assign full      = (lap_count_q == CNT_MAX);

endmodule

// File: tb/tb_lap_recorder.sv
// Bench for lap_recorder: directed scenarios plus random pulses, checked against
// a queue-based model of the stored laps.
module tb_lap_recorder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  min_in = '0;
    logic [7:0]  sec_in = '0;
    logic        cnt_en = 1'b0;
    logic        lap_pulse = 1'b0;
    logic        view_pulse = 1'b0;
    logic        clr_pulse = 1'b0;
    logic [15:0] display;
    logic [3:0]  lap_count;
    logic [2:0]  view_idx;
    logic        recall;
    logic        full;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] laps [$];
    logic        m_recall = 1'b0;
    int          m_age = 0;
    logic [15:0] m_disp = '0;

    always #5 clk = ~clk;

    lap_recorder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .min_in    (min_in),
        .sec_in    (sec_in),
        .cnt_en    (cnt_en),
        .lap_pulse (lap_pulse),
        .view_pulse(view_pulse),
        .clr_pulse (clr_pulse),
        .display   (display),
        .lap_count (lap_count),
        .view_idx  (view_idx),
        .recall    (recall),
        .full      (full)
    );

    // Reference: laps queue holds stored times oldest..newest; m_age counts back from newest.
    task automatic model_update();
        logic [15:0] live;
        live = {min_in, sec_in};
        if (rst) begin
            laps.delete();
            m_recall = 1'b0;
            m_age    = 0;
        end else if (clr_pulse) begin
            laps.delete();
            m_recall = 1'b0;
            m_age    = 0;
        end else if (!m_recall) begin
            if (lap_pulse && cnt_en) begin
                if (laps.size() == DEPTH) void'(laps.pop_front());
                laps.push_back(live);
            end else if (view_pulse && laps.size() > 0) begin
                m_recall = 1'b1;
                m_age    = 0;
            end
        end else begin
            if (lap_pulse) begin
                m_recall = 1'b0;
                m_age    = 0;
            end else if (view_pulse) begin
                if (m_age == laps.size() - 1) begin
                    m_recall = 1'b0;
                    m_age    = 0;
                end else begin
                    m_age++;
                end
            end
        end
        if (rst) m_disp = '0;
        else     m_disp = m_recall ? laps[laps.size() - 1 - m_age] : live;
    endtask

    function automatic logic [24:0] exp_vec();
        logic [3:0] c;
        logic [2:0] a;
        c = 4'(laps.size());
        a = 3'(m_age);
        return {m_disp, c, a, m_recall, (laps.size() == DEPTH)};
    endfunction

    task automatic tick(input bit r, input bit lp, input bit vp, input bit cp);
        rst = r; lap_pulse = lp; view_pulse = vp; clr_pulse = cp;
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 1'b0; lap_pulse = 1'b0; view_pulse = 1'b0; clr_pulse = 1'b0;
    endtask

    task automatic set_time(input logic [7:0] m, input logic [7:0] s);
        min_in = m;
        sec_in = s;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 0);
        n_tests++;
        if ({display, lap_count, view_idx, recall, full} !== {16'h0000, 4'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got=%h required=%h",
                     {display, lap_count, view_idx, recall, full}, 25'h0);
        end
        set_time(8'h12, 8'h34);
        cnt_en = 1'b1;
        tick(0, 0, 0, 0);
        n_tests++;
        if (display !== 16'h1234 || lap_count !== 4'd0 || recall !== 1'b0) begin
            n_fail++;
            $display("FAIL live_latency got disp=%h cnt=%0d rec=%b required disp=1234 cnt=0 rec=0",
                     display, lap_count, recall);
        end
    endtask

    task automatic test_recall_walk();
        logic [15:0] want [3];
        want[0] = 16'h0015; want[1] = 16'h0010; want[2] = 16'h0005;
        tick(0, 0, 0, 1);
        set_time(8'h00, 8'h05); tick(0, 1, 0, 0);
        set_time(8'h00, 8'h10); tick(0, 1, 0, 0);
        set_time(8'h00, 8'h15); tick(0, 1, 0, 0);
        set_time(8'h00, 8'h20);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0);
            n_tests++;
            if (display !== want[i] || view_idx !== 3'(i) || recall !== 1'b1) begin
                n_fail++;
                $display("FAIL recall_step%0d got disp=%h idx=%0d rec=%b required disp=%h idx=%0d rec=1",
                         i, display, view_idx, recall, want[i], i);
            end
        end
        tick(0, 0, 1, 0);
        n_tests++;
        if (recall !== 1'b0 || display !== 16'h0020 || view_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL recall_exit got disp=%h idx=%0d rec=%b required disp=0020 idx=0 rec=0",
                     display, view_idx, recall);
        end
    endtask

    task automatic test_wrap();
        tick(0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            set_time(8'h00, 8'(i));
            tick(0, 1, 0, 0);
        end
        n_tests++;
        if (full !== 1'b1 || lap_count !== 4'd8) begin
            n_fail++;
            $display("FAIL wrap_full got full=%b cnt=%0d required full=1 cnt=8", full, lap_count);
        end
        tick(0, 0, 1, 0);
        n_tests++;
        if (display !== 16'h0009) begin
            n_fail++;
            $display("FAIL wrap_newest got=%h required=0009", display);
        end
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 0);
        n_tests++;
        if (display !== 16'h0002 || view_idx !== 3'd7 || recall !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_oldest got disp=%h idx=%0d rec=%b required disp=0002 idx=7 rec=1",
                     display, view_idx, recall);
        end
        tick(0, 0, 1, 0);
        n_tests++;
        if ({display, lap_count, view_idx, recall, full} !== exp_vec()) begin
            n_fail++;
            $display("FAIL wrap_exit got=%h required=%h", {display, lap_count, view_idx, recall, full}, exp_vec());
        end
    endtask

    task automatic test_ignored();
        tick(0, 0, 0, 1);
        cnt_en = 1'b0;
        set_time(8'h03, 8'h33);
        tick(0, 1, 0, 0);
        n_tests++;
        if (lap_count !== 4'd0) begin
            n_fail++;
            $display("FAIL lap_stopped got cnt=%0d required cnt=0", lap_count);
        end
        tick(0, 0, 1, 0);
        n_tests++;
        if (recall !== 1'b0 || display !== 16'h0333) begin
            n_fail++;
            $display("FAIL view_empty got rec=%b disp=%h required rec=0 disp=0333", recall, display);
        end
        cnt_en = 1'b1;
        tick(0, 1, 0, 0);
        cnt_en = 1'b0;
        tick(0, 1, 0, 0);
        n_tests++;
        if (lap_count !== 4'd1) begin
            n_fail++;
            $display("FAIL lap_stopped_nonempty got cnt=%0d required cnt=1", lap_count);
        end
        cnt_en = 1'b1;
    endtask

    task automatic test_coincide();
        tick(0, 0, 0, 1);
        set_time(8'h45, 8'h07);
        tick(0, 1, 1, 0);
        n_tests++;
        if (lap_count !== 4'd1 || recall !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_view_same got cnt=%0d rec=%b required cnt=1 rec=0", lap_count, recall);
        end
        tick(0, 0, 1, 0);
        set_time(8'h46, 8'h00);
        tick(0, 1, 1, 0);
        n_tests++;
        if (lap_count !== 4'd1 || recall !== 1'b0 || display !== 16'h4600) begin
            n_fail++;
            $display("FAIL recall_lap_nostore got cnt=%0d rec=%b disp=%h required cnt=1 rec=0 disp=4600",
                     lap_count, recall, display);
        end
        tick(0, 1, 0, 1);
        n_tests++;
        if (lap_count !== 4'd0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_lap_same got cnt=%0d required cnt=0", lap_count);
        end
    endtask

    task automatic test_reset_in_recall();
        tick(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            set_time(8'h01, 8'(8'h10 + i));
            tick(0, 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
        n_tests++;
        if (recall !== 1'b1 || view_idx !== 3'd2 || display !== 16'h0110) begin
            n_fail++;
            $display("FAIL pre_rst_recall got rec=%b idx=%0d disp=%h required rec=1 idx=2 disp=0110",
                     recall, view_idx, display);
        end
        tick(1, 0, 1, 0);
        n_tests++;
        if ({display, lap_count, view_idx, recall, full} !== {16'h0000, 4'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_in_recall got=%h required=%h",
                     {display, lap_count, view_idx, recall, full}, 25'h0);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 1500; i++) begin
            set_time(8'($urandom), 8'($urandom));
            cnt_en = ($urandom_range(0, 9) < 8);
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
            n_tests++;
            if ({display, lap_count, view_idx, recall, full} !== exp_vec()) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle%0d got=%h required=%h",
                             i, {display, lap_count, view_idx, recall, full}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_recall_walk();
        test_wrap();
        test_ignored();
        test_coincide();
        test_reset_in_recall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lap_recorder.md
LAP_RECORDER -- requirements
Module: lap_recorder

Interface
REQ-001 Parameter DEPTH, default 8, number of lap entries stored; legal values 2..8.
REQ-002 clk  input  1  clock; the scan-rate clock shared with the push-button and control stages.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 min_in  input  8  live minutes as two BCD digits {tens, ones}.
REQ-005 sec_in  input  8  live seconds as two BCD digits {tens, ones}.
REQ-006 cnt_en  input  1  high while the stopwatch is counting.
REQ-007 lap_pulse  input  1  one-cycle debounced lap request.
REQ-008 view_pulse  input  1  one-cycle debounced recall/step request.
REQ-009 clr_pulse  input  1  one-cycle request to erase all stored laps.
REQ-010 display  output  16  four BCD digits {min tens, min ones, sec tens, sec ones} to the decoders.
REQ-011 lap_count  output  4  number of valid stored laps, 0..DEPTH.
REQ-012 view_idx  output  3  age of the shown entry: 0 = newest.
REQ-013 recall  output  1  high in RECALL state.
REQ-014 full  output  1  high when lap_count == DEPTH.

Function
REQ-015 The block SHALL hold DEPTH 16-bit entries in a circular buffer with a write pointer wr_ptr (0..DEPTH-1) and an occupancy counter lap_count.
REQ-016 The block SHALL have two states: LIVE and RECALL.
REQ-017 In LIVE, display SHALL equal {min_in, sec_in} registered, i.e. one clk of latency.
REQ-018 In LIVE, lap_pulse with cnt_en=1 SHALL write {min_in, sec_in} at wr_ptr, advance wr_ptr modulo DEPTH, and increment lap_count, saturating at DEPTH.
REQ-019 When full, a store SHALL overwrite the oldest entry; lap_count stays DEPTH.
REQ-020 In LIVE, lap_pulse with cnt_en=0 SHALL be ignored.
REQ-021 In LIVE, view_pulse with lap_count>0 SHALL enter RECALL with view_idx=0; with lap_count=0 it SHALL be ignored.
REQ-022 In RECALL, display SHALL show entry at (wr_ptr-1-view_idx) mod DEPTH, registered, one clk latency.
REQ-023 In RECALL, view_pulse SHALL increment view_idx; if view_idx == lap_count-1 it SHALL instead return to LIVE with view_idx=0.
REQ-024 In RECALL, lap_pulse SHALL return to LIVE with view_idx=0 and SHALL NOT store.
REQ-025 Counting continues unaffected in RECALL; live values are not stored during RECALL.
REQ-026 clr_pulse in any state SHALL set lap_count=0, wr_ptr=0, view_idx=0, state LIVE; stored data need not be zeroed.
REQ-027 Priority when pulses coincide: clr_pulse > lap_pulse > view_pulse; the lower-priority pulse is dropped.
REQ-028 Inputs SHALL be passed through unchanged; no BCD validation or arithmetic on entries.

Reset
REQ-029 With rst=1 at a clk edge: state LIVE, wr_ptr=0, lap_count=0, view_idx=0, recall=0, full=0, display=16'h0000.
REQ-030 rst mid-RECALL SHALL abandon recall immediately; rst overrides all pulses.

Verification
REQ-031 Reset then min/sec=12:34, cnt_en=1 -> display=16'h1234 one clk later, lap_count=0, recall=0.
REQ-032 Laps at 00:05, 00:10, 00:15; view_pulse x3 -> display 0015, 0010, 0005 with view_idx 0,1,2; 4th view_pulse -> recall=0, display live.
REQ-033 DEPTH=8, 9 laps at 00:01..00:09 -> full=1, lap_count=8; recall newest=0009, 8th step=0002 (0001 overwritten).
REQ-034 lap_pulse with cnt_en=0 -> lap_count unchanged; view_pulse with lap_count=0 -> recall stays 0.
REQ-035 lap_pulse and view_pulse same cycle in LIVE -> one entry stored, recall=0; clr_pulse with lap_pulse -> lap_count=0.
REQ-036 rst asserted while recall=1, view_idx=2 -> next clk recall=0, view_idx=0, lap_count=0, display=0000.
